// File: rtl/fabric_config_loader_pkg.sv
// Shared types and constants for the fabric configuration loader.
package fabric_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        CHECK,
        WRITE,
        ERROR
    } cfg_state_e;

    localparam logic [7:0] SYNC      = 8'hA5;   // frame start
    localparam logic [7:0] ENDC      = 8'h5A;   // end of configuration

    localparam int         LT_BITS   = 33;      // 32 LUT bits + registered-output select
    localparam int         SB_BITS   = 16;      // switch-box configure word
    localparam int         ASM_BYTES = 5;       // assembler depth in bytes (40 bits)

    localparam logic [2:0] LT_NBYTES = 3'd5;
    localparam logic [2:0] SB_NBYTES = 3'd2;

    localparam logic       TYPE_LT   = 1'b0;
    localparam logic       TYPE_SB   = 1'b1;

    // Number of DATA bytes carried by a frame of the given target type.
    function automatic logic [2:0] frame_nbytes(input logic frame_type);
        return (frame_type == TYPE_SB) ? SB_NBYTES : LT_NBYTES;
    endfunction

endpackage

// File: rtl/fabric_config_loader_if.sv
// Host byte stream into the loader: valid/ready handshake with one byte per transfer.
interface fabric_config_loader_if;

    logic       cfg_valid;
    logic [7:0] cfg_byte;
    logic       cfg_ready;

    // Host / boot side drives bytes.
    modport master (
        output cfg_valid,
        output cfg_byte,
        input  cfg_ready
    );

    // Loader side consumes bytes.
    modport slave (
        input  cfg_valid,
        input  cfg_byte,
        output cfg_ready
    );

endinterface

// File: rtl/fabric_config_loader_assembler.sv
// Little-endian 40-bit word assembler with a running XOR over the loaded bytes.
module fabric_cfg_assembler
    import fabric_cfg_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [2:0]  byte_idx,
    input  logic [7:0]  byte_in,
    output logic [39:0] word,
    output logic [7:0]  chk
);

    logic [39:0] word_q;
    logic [7:0]  chk_q;

    // Drop each byte into its slot and fold it into the checksum; clear zeroes the
    // upper bytes so short (switch-box) frames come out zero-extended.
    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values; the assembler is a handful of flops, so it is reset too.
        if (reset || clear) begin
            word_q <= '0;
            chk_q  <= '0;
        end else if (load) begin
            for (int i = 0; i < ASM_BYTES; i++) begin
                if (byte_idx == 3'(i)) begin
                    word_q[i*8 +: 8] <= byte_in;
                end
            end
            chk_q <= chk_q ^ byte_in;
        end
    end

    assign word = word_q;
    assign chk  = chk_q;

endmodule

// File: rtl/fabric_config_loader.sv
// Framed configuration byte loader: parses SYNC/ADDR/DATA/CHK frames and issues
// one write strobe per good frame; keeps the fabric in clear until ENDC.
module fabric_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter int N_LT = 17,
    parameter int N_SB = 41
) (
    input  logic                  clock,
    input  logic                  reset,
    fabric_config_loader_if.slave host,
    output logic                  cfg_we,
    output logic                  cfg_type,
    output logic [6:0]            cfg_addr,
    output logic [LT_BITS-1:0]    cfg_data,
    output logic                  fabric_en,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic [7:0]            frame_cnt
);

    localparam logic [7:0] LT_LIMIT = 8'(N_LT);
    localparam logic [7:0] SB_LIMIT = 8'(N_SB);

    cfg_state_e         state_q, state_d;
    logic               accept;
    logic               frame_type_q;
    logic [6:0]         frame_idx_q;
    logic [2:0]         byte_cnt_q;
    logic               addr_ok, chk_ok, last_byte;
    logic               asm_clear, asm_load;
    logic [39:0]        asm_word;
    logic [7:0]         asm_chk;
    logic               asm_unused;
    logic               cfg_type_q;
    logic [6:0]         cfg_addr_q;
    logic [LT_BITS-1:0] cfg_data_q;
    logic               fabric_en_q, cfg_done_q, cfg_err_q;
    logic [7:0]         frame_cnt_q;

    assign accept    = host.cfg_valid & host.cfg_ready;
    assign addr_ok   = host.cfg_byte[7] ? ({1'b0, host.cfg_byte[6:0]} < SB_LIMIT)
                                        : ({1'b0, host.cfg_byte[6:0]} < LT_LIMIT);
    // The checksum also covers the ADDR byte, which is held in the frame registers.
    assign chk_ok    = host.cfg_byte == (asm_chk ^ {frame_type_q, frame_idx_q});
    assign last_byte = byte_cnt_q == (frame_nbytes(frame_type_q) - 3'd1);
    // Bits 39:33 of the assembled word are discarded.
    assign asm_unused = ^asm_word[39:LT_BITS];

    fabric_cfg_assembler u_assembler (
        .clock    (clock),
        .reset    (reset),
        .clear    (asm_clear),
        .load     (asm_load),
        .byte_idx (byte_cnt_q),
        .byte_in  (host.cfg_byte),
        .word     (asm_word),
        .chk      (asm_chk)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; frames advance only on accepted bytes.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && host.cfg_byte == SYNC) state_d = ADDR;
            ADDR:    if (accept) state_d = addr_ok ? DATA : ERROR;
            DATA:    if (accept && last_byte) state_d = CHECK;
            CHECK:   if (accept) state_d = chk_ok ? WRITE : ERROR;
            WRITE:   state_d = IDLE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs and assembler controls.
    always_comb begin
        cfg_we         = (state_q == WRITE);
        host.cfg_ready = (state_q != WRITE);
        asm_clear      = accept && (state_q == ADDR);
        asm_load       = accept && (state_q == DATA);
    end

    // Frame header capture and DATA byte counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_type_q <= TYPE_LT;
            frame_idx_q  <= '0;
            byte_cnt_q   <= '0;
        end else if (accept && state_q == ADDR) begin
            frame_type_q <= host.cfg_byte[7];
            frame_idx_q  <= host.cfg_byte[6:0];
            byte_cnt_q   <= '0;
        end else if (accept && state_q == DATA) begin
            byte_cnt_q   <= byte_cnt_q + 3'd1;
        end
    end

    // Write-port registers and frame counter, loaded only on entry to WRITE.
    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_type_q  <= TYPE_LT;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            frame_cnt_q <= '0;
        end else if (state_q == CHECK && state_d == WRITE) begin
            cfg_type_q  <= frame_type_q;
            cfg_addr_q  <= frame_idx_q;
            cfg_data_q  <= (frame_type_q == TYPE_SB)
                           ? {{(LT_BITS-SB_BITS){1'b0}}, asm_word[SB_BITS-1:0]}
                           : asm_word[LT_BITS-1:0];
            if (frame_cnt_q != 8'hFF) frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    // Fabric enable / done / sticky error status.
    always_ff @(posedge clock) begin
        if (reset) begin
            fabric_en_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else if (state_d == ERROR) begin
            fabric_en_q <= 1'b0;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b1;
        end else if (accept && state_q == IDLE) begin
            if (host.cfg_byte == SYNC) begin
                fabric_en_q <= 1'b0;
                cfg_done_q  <= 1'b0;
            end else if (host.cfg_byte == ENDC) begin
                fabric_en_q <= 1'b1;
                cfg_done_q  <= 1'b1;
            end
        end
    end

    assign cfg_type  = cfg_type_q;
    assign cfg_addr  = cfg_addr_q;
    assign cfg_data  = cfg_data_q;
    assign fabric_en = fabric_en_q;
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Self-checking bench for fabric_config_loader: directed frame vectors, hand-written
// reset/saturation sequences and random byte streams against a frame-level model.
module tb_fabric_config_loader;
    import fabric_cfg_pkg::*;

    localparam int N_LT = 17;
    localparam int N_SB = 41;

    logic        clock;
    logic        reset;
    logic        cfg_we;
    logic        cfg_type;
    logic [6:0]  cfg_addr;
    logic [32:0] cfg_data;
    logic        fabric_en;
    logic        cfg_done;
    logic        cfg_err;
    logic [7:0]  frame_cnt;

    fabric_config_loader_if host_if ();

    fabric_config_loader #(.N_LT(N_LT), .N_SB(N_SB)) dut (
        .clock     (clock),
        .reset     (reset),
        .host      (host_if),
        .cfg_we    (cfg_we),
        .cfg_type  (cfg_type),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .fabric_en (fabric_en),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .frame_cnt (frame_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes_seen = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level reference model: buffers a frame's bytes and judges it as a whole.
    logic        m_in_frame;
    logic [7:0]  m_buf[$];
    logic        m_err, m_en, m_done, m_we, m_type;
    logic [6:0]  m_addr;
    logic [32:0] m_data;
    logic [7:0]  m_fcnt;

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_buf.delete();
        m_err = 1'b0; m_en = 1'b0; m_done = 1'b0; m_we = 1'b0;
        m_type = 1'b0; m_addr = '0; m_data = '0; m_fcnt = '0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n;
        int lim;
        logic [7:0]  x;
        logic [39:0] w;
        m_we = 1'b0;
        if (m_err) return;
        if (!m_in_frame) begin
            if (b == SYNC) begin
                m_in_frame = 1'b1; m_buf.delete(); m_en = 1'b0; m_done = 1'b0;
            end else if (b == ENDC) begin
                m_en = 1'b1; m_done = 1'b1;
            end
            return;
        end
        m_buf.push_back(b);
        if (m_buf.size() == 1) begin
            lim = b[7] ? N_SB : N_LT;
            if (int'(b[6:0]) >= lim) begin
                m_err = 1'b1; m_en = 1'b0; m_done = 1'b0; m_in_frame = 1'b0;
            end
            return;
        end
        n = m_buf[0][7] ? 2 : 5;
        if (m_buf.size() < n + 2) return;
        x = '0;
        w = '0;
        for (int k = 0; k <= n; k++) x = x ^ m_buf[k];
        for (int k = 0; k < n; k++) w = w | (40'(m_buf[1+k]) << (8*k));
        m_in_frame = 1'b0;
        if (x == m_buf[n+1]) begin
            m_we = 1'b1; m_type = m_buf[0][7]; m_addr = m_buf[0][6:0]; m_data = w[32:0];
            if (m_fcnt != 8'hFF) m_fcnt = m_fcnt + 8'd1;
        end else begin
            m_err = 1'b1; m_en = 1'b0; m_done = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_we"},    40'(cfg_we),            40'(m_we));
        check({tag, "_ready"}, 40'(host_if.cfg_ready), 40'(!m_we));
        check({tag, "_type"},  40'(cfg_type),          40'(m_type));
        check({tag, "_addr"},  40'(cfg_addr),          40'(m_addr));
        check({tag, "_data"},  40'(cfg_data),          40'(m_data));
        check({tag, "_err"},   40'(cfg_err),           40'(m_err));
        check({tag, "_en"},    40'(fabric_en),         40'(m_en));
        check({tag, "_done"},  40'(cfg_done),          40'(m_done));
        check({tag, "_fcnt"},  40'(frame_cnt),         40'(m_fcnt));
    endtask

    // Called at a negedge; holds valid low for 'gap' cycles, then offers the byte
    // until ready, and checks every output in the cycle after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        host_if.cfg_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clock);
            check("gap_we", 40'(cfg_we), 40'(1'b0));
        end
        host_if.cfg_valid = 1'b1;
        host_if.cfg_byte  = b;
        waited = 0;
        while (host_if.cfg_ready !== 1'b1 && waited < 8) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 8) begin
            check("ready_timeout", 40'(host_if.cfg_ready), 40'(1'b1));
            host_if.cfg_valid = 1'b0;
            return;
        end
        model_byte(b);
        @(negedge clock);
        host_if.cfg_valid = 1'b0;
        if (cfg_we === 1'b1) n_writes_seen++;
        check_outputs("byte");
    endtask

    task automatic send_stream(input logic [127:0] s, input int len, input int gap);
        for (int i = 0; i < len; i++) send_byte(s[8*(len-1-i) +: 8], gap);
    endtask

    task automatic do_reset();
        host_if.cfg_valid = 1'b0;
        host_if.cfg_byte  = 8'h00;
        reset = 1'b1;
        @(negedge clock);
        model_reset();
        check_outputs("reset");
        reset = 1'b0;
    endtask

    task automatic send_random_frame(input int max_gap);
        logic       t;
        int         idx, lim, n;
        logic [7:0] bytes[$];
        logic [7:0] x, d;
        t   = 1'($urandom_range(0, 1));
        lim = t ? N_SB : N_LT;
        if ($urandom_range(0, 15) == 0) idx = lim + int'($urandom_range(0, 127 - lim));
        else                            idx = int'($urandom_range(0, lim - 1));
        n = t ? 2 : 5;
        bytes.push_back(SYNC);
        x = {t, 7'(idx)};
        bytes.push_back(x);
        for (int k = 0; k < n; k++) begin
            d = 8'($urandom);
            bytes.push_back(d);
            x = x ^ d;
        end
        if ($urandom_range(0, 19) == 0) x = x ^ (8'h01 << $urandom_range(0, 7));
        bytes.push_back(x);
        foreach (bytes[k]) send_byte(bytes[k], int'($urandom_range(0, max_gap)));
    endtask

    typedef struct {
        logic [127:0] stream;   // bytes right-justified, first byte most significant
        int           len;
        int           gap;
        logic         e_type;
        logic [6:0]   e_addr;
        logic [32:0]  e_data;
        logic         e_err;
        logic         e_en;
        logic         e_done;
        logic [7:0]   e_fcnt;
        int           e_writes;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [127:0] s, input int len, input int gap,
                           input logic e_type, input logic [6:0] e_addr, input logic [32:0] e_data,
                           input logic e_err, input logic e_en, input logic e_done,
                           input logic [7:0] e_fcnt, input int e_writes);
        vec_t v;
        v.stream = s; v.len = len; v.gap = gap;
        v.e_type = e_type; v.e_addr = e_addr; v.e_data = e_data;
        v.e_err = e_err; v.e_en = e_en; v.e_done = e_done;
        v.e_fcnt = e_fcnt; v.e_writes = e_writes;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        host_if.cfg_valid = 1'b0;
        host_if.cfg_byte  = 8'h00;

        // LT load, chk = 03^EF^BE^AD^DE^01 = 20
        add_vec(128'({8'hA5, 8'h03, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h20}), 8, 0,
                1'b0, 7'd3, 33'h1_DEAD_BEEF, 1'b0, 1'b0, 1'b0, 8'd1, 1);
        // SB load then ENDC, chk = 85^34^12 = A3
        add_vec(128'({8'hA5, 8'h85, 8'h34, 8'h12, 8'hA3, 8'h5A}), 6, 1,
                1'b1, 7'd5, 33'h1234, 1'b0, 1'b1, 1'b1, 8'd1, 1);
        // Bad checksum, then a good frame and ENDC that must be ignored
        add_vec(128'({8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF,
                      8'hA5, 8'h85, 8'h34, 8'h12, 8'hA3, 8'h5A}), 14, 0,
                1'b0, 7'd0, 33'h0, 1'b1, 1'b0, 1'b0, 8'd0, 0);
        // SB index 41 is out of range
        add_vec(128'({8'hA5, 8'hA9, 8'h85, 8'h34, 8'h12, 8'hA3, 8'h5A}), 7, 2,
                1'b0, 7'd0, 33'h0, 1'b1, 1'b0, 1'b0, 8'd0, 0);
        // SB index 40 is the last valid switch box, chk = A8^01^80 = 29
        add_vec(128'({8'hA5, 8'hA8, 8'h01, 8'h80, 8'h29}), 5, 0,
                1'b1, 7'd40, 33'h8001, 1'b0, 1'b0, 1'b0, 8'd1, 1);
        // LT index 16, all-ones data: bits 39:33 dropped, chk = 10^FF = EF
        add_vec(128'({8'hA5, 8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hEF}), 8, 1,
                1'b0, 7'd16, 33'h1_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 8'd1, 1);
        // LT index 17 is out of range
        add_vec(128'({8'hA5, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11}), 8, 0,
                1'b0, 7'd0, 33'h0, 1'b1, 1'b0, 1'b0, 8'd0, 0);
        // ENDC, reconfigure SB 1 (chk = 81^07^00 = 86), ENDC again
        add_vec(128'({8'h5A, 8'hA5, 8'h81, 8'h07, 8'h00, 8'h86, 8'h5A}), 7, 0,
                1'b1, 7'd1, 33'h7, 1'b0, 1'b1, 1'b1, 8'd1, 1);
        // Junk in IDLE, SYNC/ENDC values as data, chk = 02
        add_vec(128'({8'h00, 8'h33, 8'hA5, 8'h02, 8'hA5, 8'h5A, 8'hA5, 8'h5A, 8'h00, 8'h02}), 10, 0,
                1'b0, 7'd2, 33'h0_5AA5_5AA5, 1'b0, 1'b0, 1'b0, 8'd1, 1);
        // Back-to-back SB then LT frames with valid held continuously
        add_vec(128'({8'hA5, 8'h85, 8'h34, 8'h12, 8'hA3,
                      8'hA5, 8'h03, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h20}), 13, 0,
                1'b0, 7'd3, 33'h1_DEAD_BEEF, 1'b0, 1'b0, 1'b0, 8'd2, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            n_writes_seen = 0;
            send_stream(vecs[i].stream, vecs[i].len, vecs[i].gap);
            @(negedge clock);
            check($sformatf("v%0d_writes", i), 40'(n_writes_seen), 40'(vecs[i].e_writes));
            check($sformatf("v%0d_type", i),   40'(cfg_type),      40'(vecs[i].e_type));
            check($sformatf("v%0d_addr", i),   40'(cfg_addr),      40'(vecs[i].e_addr));
            check($sformatf("v%0d_data", i),   40'(cfg_data),      40'(vecs[i].e_data));
            check($sformatf("v%0d_err", i),    40'(cfg_err),       40'(vecs[i].e_err));
            check($sformatf("v%0d_en", i),     40'(fabric_en),     40'(vecs[i].e_en));
            check($sformatf("v%0d_done", i),   40'(cfg_done),      40'(vecs[i].e_done));
            check($sformatf("v%0d_fcnt", i),   40'(frame_cnt),     40'(vecs[i].e_fcnt));
        end

        // Reset in the middle of DATA after a completed load: everything returns to
        // reset values, then a fresh frame loads normally.
        do_reset();
        send_stream(128'({8'hA5, 8'h85, 8'h34, 8'h12, 8'hA3, 8'h5A}), 6, 0);
        send_stream(128'({8'hA5, 8'h03, 8'hEF, 8'hBE}), 4, 0);
        do_reset();
        check("midrst_data", 40'(cfg_data),  40'(33'h0));
        check("midrst_fcnt", 40'(frame_cnt), 40'(8'h00));
        send_stream(128'({8'hA5, 8'h03, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h20}), 8, 0);
        check("midrst_reload_data", 40'(cfg_data),  40'(33'h1_DEAD_BEEF));
        check("midrst_reload_fcnt", 40'(frame_cnt), 40'(8'h01));

        // Frame counter saturation.
        do_reset();
        for (int f = 0; f < 257; f++) begin
            send_stream(128'({8'hA5, 8'h85, 8'h34, 8'h12, 8'hA3}), 5, 0);
        end
        check("sat_fcnt", 40'(frame_cnt), 40'(8'hFF));

        // Random streams: frames, junk and ENDC with random valid gaps.
        for (int s = 0; s < 4; s++) begin
            do_reset();
            for (int f = 0; f < 30; f++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r == 0)      send_byte(8'($urandom), int'($urandom_range(0, 2)));
                else if (r == 1) send_byte(ENDC, int'($urandom_range(0, 2)));
                else             send_random_frame((s == 0) ? 0 : 3);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
